// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-to-one imem/dmem arbiter for the unified memory port with watchdog (ARB_RR_EN selects round-robin)
module mem_port_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  // Counter wide enough to hold TIMEOUT itself so it can saturate there
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t state, state_nxt;
  logic   i_pend, d_pend, pick_d;
  logic   grant_i, grant_d, grant, serving, stall;
  logic [CW-1:0] wd_cnt, wd_inc;

  assign i_pend  = |imem_rmask;
  assign d_pend  = (|dmem_rmask) || (|dmem_wmask);
  assign grant   = grant_i || grant_d;
  assign serving = (state != IDLE);
  assign stall   = serving && !mem_resp;
  assign wd_inc  = wd_cnt + CW'(1);

`ifdef ARB_RR_EN
  logic fav_d;

  // Tie-break pointer: after an imem grant dmem is favoured, and vice versa
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fav_d <= 1'b1;
    end else if (grant) begin
      fav_d <= grant_i;
    end
  end

  assign pick_d = d_pend && (!i_pend || fav_d);
`else
  assign pick_d = d_pend;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant selection in IDLE and zero-latency response routing while serving
  always_comb begin
    state_nxt  = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    imem_resp  = 1'b0;
    dmem_resp  = 1'b0;
    imem_rdata = 32'h0;
    dmem_rdata = 32'h0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          grant_d   = 1'b1;
          state_nxt = SERVE_D;
        end else if (i_pend) begin
          grant_i   = 1'b1;
          state_nxt = SERVE_I;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_rdata;
          state_nxt  = IDLE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          dmem_resp  = 1'b1;
          dmem_rdata = mem_rdata;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side request: captured on the grant edge, held, cleared on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= 32'h0;
      mem_rmask <= 4'h0;
      mem_wmask <= 4'h0;
      mem_wdata <= 32'h0;
    end else if (grant_d) begin
      mem_addr  <= {dmem_addr[31:2], 2'b00};
      // A request carrying both masks is executed as a store only
      mem_rmask <= (|dmem_wmask) ? 4'h0 : dmem_rmask;
      mem_wmask <= dmem_wmask;
      mem_wdata <= dmem_wdata;
    end else if (grant_i) begin
      mem_addr  <= {imem_addr[31:2], 2'b00};
      mem_rmask <= imem_rmask;
      mem_wmask <= 4'h0;
      mem_wdata <= 32'h0;
    end else if (serving && mem_resp) begin
      mem_addr  <= 32'h0;
      mem_rmask <= 4'h0;
      mem_wmask <= 4'h0;
      mem_wdata <= 32'h0;
    end
  end

  // Watchdog: wd_cnt holds the stalled cycles already waited; the sticky flag
  // is raised so it shows during the SERVE cycle in which the wait reaches TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      arb_timeout <= 1'b0;
    end else begin
      if (grant) begin
        wd_cnt <= '0;
      end else if (stall && (wd_cnt != WD_MAX)) begin
        wd_cnt <= wd_inc;
      end
      if ((TIMEOUT != 0) &&
          ((grant && (WD_LAST == '0)) || (stall && (wd_inc == WD_LAST)))) begin
        arb_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr = '0;
  logic [3:0]  imem_rmask = '0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_rmask = '0;
  logic [3:0]  dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        arb_timeout;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          load;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_i[$];
  txn_t exp_d[$];
  bit   grant_log[$];
  logic [31:0] marr [int unsigned];
  logic [31:0] dref [int unsigned];
  int   fixed_lat = -1;
  bit   withhold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if ({a[31:2], 2'b00} == 32'h6000_0000) return 32'h1234_5678;
    return {a[31:2], 2'b00} ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory model: answers each request after a configurable latency
  initial begin : responder
    int lat;
    int unsigned k;
    logic [31:0] w;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && !withhold && (mem_rmask != 0 || mem_wmask != 0)) begin
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        repeat (lat) @(negedge clk);
        @(posedge clk); #1;
        k = {2'b00, mem_addr[31:2]};
        w = marr.exists(k) ? marr[k] : init_word(mem_addr);
        if (mem_wmask != 0) marr[k] = merge(w, mem_wdata, mem_wmask);
        mem_rdata = w;
        mem_resp = 1'b1;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  // Monitor: tracks grants by the arbitration rule and scores every cycle
  initial begin : monitor
    bit busy, side_d, exp_to, fav_d;
    int cyc;
    txn_t t;
    busy = 0; side_d = 0; exp_to = 0; fav_d = 1; cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; exp_to = 0; fav_d = 1;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_masks", {24'h0, mem_rmask, mem_wmask}, 0);
        chk("rst_resp", {30'h0, imem_resp, dmem_resp}, 0);
        chk("rst_timeout", {31'h0, arb_timeout}, 0);
      end else if (busy) begin
        cyc++;
        if (cyc >= TO) exp_to = 1;
        chk("timeout_flag", {31'h0, arb_timeout}, {31'h0, exp_to});
        if ((side_d ? exp_d.size() : exp_i.size()) == 0) begin
          chk("sb_underflow", 1, 0);
          busy = 0;
        end else begin
          t = side_d ? exp_d[0] : exp_i[0];
          chk(side_d ? "d_mem_addr" : "i_mem_addr", mem_addr, t.addr);
          chk(side_d ? "d_mem_rmask" : "i_mem_rmask", {28'h0, mem_rmask}, {28'h0, t.rmask});
          chk(side_d ? "d_mem_wmask" : "i_mem_wmask", {28'h0, mem_wmask}, {28'h0, t.wmask});
          chk(side_d ? "d_mem_wdata" : "i_mem_wdata", mem_wdata, t.wdata);
          if (mem_resp) begin
            chk("imem_resp", {31'h0, imem_resp}, {31'h0, !side_d});
            chk("dmem_resp", {31'h0, dmem_resp}, {31'h0, side_d});
            if (side_d) begin
              if (t.load) chk("dmem_rdata", dmem_rdata, t.rdata);
              chk("imem_rdata_idle", imem_rdata, 0);
              void'(exp_d.pop_front());
            end else begin
              chk("imem_rdata", imem_rdata, t.rdata);
              chk("dmem_rdata_idle", dmem_rdata, 0);
              void'(exp_i.pop_front());
            end
            busy = 0;
          end else begin
            chk("resp_while_wait", {30'h0, imem_resp, dmem_resp}, 0);
          end
        end
      end else begin
        chk("idle_mem", {mem_rmask, mem_wmask} | {24'h0, mem_addr[7:0]} | mem_wdata, 0);
        chk("idle_resp", {30'h0, imem_resp, dmem_resp}, 0);
        chk("idle_rdata", imem_rdata | dmem_rdata, 0);
        chk("idle_timeout", {31'h0, arb_timeout}, {31'h0, exp_to});
        if (imem_rmask != 0 || dmem_rmask != 0 || dmem_wmask != 0) begin
          if (dmem_rmask != 0 || dmem_wmask != 0) begin
`ifdef ARB_RR_EN
            side_d = (imem_rmask == 0) || fav_d;
`else
            side_d = 1;
`endif
          end else begin
            side_d = 0;
          end
          fav_d = !side_d;
          grant_log.push_back(side_d);
          busy = 1;
          cyc = 0;
        end
      end
    end
  end

  task automatic wait_resp(input bit d);
    int w;
    w = 0;
    do begin @(negedge clk); w++; end while (!(d ? dmem_resp : imem_resp) && w < 3000);
    if (!(d ? dmem_resp : imem_resp)) chk(d ? "dmem_wait" : "imem_wait", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic req_i(input logic [31:0] a, input logic [3:0] m);
    txn_t t;
    t.addr = {a[31:2], 2'b00}; t.rmask = m; t.wmask = 0; t.wdata = 0;
    t.rdata = init_word(a); t.load = 1;
    exp_i.push_back(t);
    imem_addr = a; imem_rmask = m;
    wait_resp(0);
    imem_rmask = 0;
  endtask

  task automatic req_d(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd);
    txn_t t;
    int unsigned k;
    logic [31:0] old;
    k = {2'b00, a[31:2]};
    old = dref.exists(k) ? dref[k] : init_word(a);
    t.addr = {a[31:2], 2'b00}; t.wmask = wm; t.wdata = wd;
    t.load = (wm == 0); t.rmask = t.load ? rm : 4'h0; t.rdata = old;
    if (!t.load) dref[k] = merge(old, wd, wm);
    exp_d.push_back(t);
    dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
    wait_resp(1);
    dmem_rmask = 0; dmem_wmask = 0;
  endtask

  task automatic loop_i(input int n, input int maxgap);
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      req_i(32'h6000_0000 | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3),
            4'($urandom_range(1, 15)));
    end
  endtask

  task automatic loop_d(input int n, input int maxgap);
    int op;
    logic [31:0] a;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      op = $urandom_range(0, 9);
      a = 32'h8000_0000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (op < 5)      req_d(a, 4'($urandom_range(1, 15)), 4'h0, $urandom);
      else if (op < 9) req_d(a, 4'h0, 4'($urandom_range(1, 15)), $urandom);
      else             req_d(a, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), $urandom);
    end
  endtask

  initial begin : watchdog_limit
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch with misaligned address
    fixed_lat = 2;
    req_i(32'h6000_0002, 4'hF);
    fixed_lat = -1;

    // Simultaneous fetch and store: dmem first, then imem after one idle cycle
    grant_log.delete();
    fork
      req_i(32'h6000_0040, 4'hF);
      req_d(32'h8000_0010, 4'h0, 4'h3, 32'h0000_ABCD);
    join
    chk("sim_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("sim_first_d", {31'h0, grant_log[0]}, 1);
      chk("sim_second_i", {31'h0, grant_log[1]}, 0);
    end

    // Both continuously pending
    grant_log.delete();
    fork
      loop_d(4, 0);
      loop_i(2, 0);
    join
    chk("cont_grants", grant_log.size(), 6);
    if (grant_log.size() >= 4) begin
`ifdef ARB_RR_EN
      chk("cont_order", {28'h0, grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 32'b1010);
`else
      chk("cont_order", {28'h0, grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 32'b1111);
`endif
    end

    // Random traffic
    fork
      loop_i(20, 3);
      loop_d(20, 3);
    join

    // Watchdog: withhold the response well past TIMEOUT
    chk("to_before", {31'h0, arb_timeout}, 0);
    withhold = 1'b1;
    fixed_lat = 1;
    fork
      req_i(32'h6000_0100, 4'hF);
      begin
        repeat (TO + 4) @(negedge clk);
        chk("to_during", {31'h0, arb_timeout}, 1);
        withhold = 1'b0;
      end
    join
    chk("to_sticky", {31'h0, arb_timeout}, 1);
    fixed_lat = -1;

    // Reset two cycles into SERVE_D
    withhold = 1'b1;
    @(posedge clk); #1;
    begin
      txn_t t;
      t.addr = 32'h8000_0020; t.rmask = 0; t.wmask = 4'hF; t.wdata = 32'hDEAD_BEEF;
      t.rdata = 0; t.load = 0;
      exp_d.push_back(t);
    end
    dmem_addr = 32'h8000_0020; dmem_wmask = 4'hF; dmem_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_wmask", {28'h0, mem_wmask}, 32'hF);
    rst = 1'b1;
    #1;
    chk("rst_async_addr", mem_addr, 0);
    chk("rst_async_wmask", {28'h0, mem_wmask}, 0);
    chk("rst_async_wdata", mem_wdata, 0);
    chk("rst_async_resp", {31'h0, dmem_resp}, 0);
    chk("rst_async_to", {31'h0, arb_timeout}, 0);
    dmem_wmask = 0;
    exp_d.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    mem_resp = 1'b1; mem_rdata = 32'hFEED_F00D;
    #1;
    chk("stray_resp", {30'h0, imem_resp, dmem_resp}, 0);
    @(posedge clk); #1;
    mem_resp = 1'b0; mem_rdata = '0;
    withhold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("end_queues", exp_i.size() + exp_d.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
